// File: rtl/ritc_vdd_servo_dac_loader.sv
// VDD servo DAC loader: stages two 12-bit servo words, commits them on an update
// edge and shifts both (R0 then R1) into the dual-channel VDD DAC over 3-wire SPI.
module ritc_vdd_servo_dac_loader #(
    parameter int unsigned CLK_DIV  = 4,
    parameter logic [1:0]  DAC_CMD  = 2'b11,
    parameter logic [1:0]  CH0_ADDR = 2'b00,
    parameter logic [1:0]  CH1_ADDR = 2'b01
) (
    input  logic        user_clk_i,
    input  logic        user_rst_i,
    input  logic        servo_addr_i,
    input  logic        servo_wr_i,
    input  logic        servo_update_i,
    input  logic [11:0] servo_i,
    output logic        DAC_SCLK,
    output logic        DAC_DIN,
    output logic        DAC_CS_B,
    output logic        busy_o,
    output logic [11:0] vdd_r0_o,
    output logic [11:0] vdd_r1_o
);

    typedef enum logic [1:0] {
        IDLE,
        COMMIT,
        SHIFT,
        GAP
    } state_t;

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic [1:0][11:0] staging_w;

    // One staging register per RITC; writes are accepted in every FSM state.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_stage
            logic [11:0] word_reg;

            always_ff @(posedge user_clk_i or posedge user_rst_i) begin
                if (user_rst_i) begin
                    word_reg <= 12'd0;
                end else if (servo_wr_i && (servo_addr_i == 1'(gi))) begin
                    word_reg <= servo_i;
                end
            end

            assign staging_w[gi] = word_reg;
        end
    endgenerate

    state_t      state_reg;
    logic        upd_q_reg;
    logic        pending_reg;
    logic        ch_sel_reg;
    logic [11:0] active_r0_reg;
    logic [11:0] active_r1_reg;
    logic [14:0] shift_reg;
    logic [7:0]  div_cnt_reg;
    logic [3:0]  bit_cnt_reg;
    logic        sclk_reg;
    logic        din_reg;
    logic        cs_b_reg;
    logic        busy_reg;

    logic        upd_edge_w;
    logic [15:0] frame0_w;
    logic [15:0] frame1_w;

    assign upd_edge_w = servo_update_i & ~upd_q_reg;
    // Channel 0 frame is built from staging because it is loaded in the same
    // cycle that staging is committed; channel 1 uses the committed copy.
    assign frame0_w   = {DAC_CMD, CH0_ADDR, staging_w[0]};
    assign frame1_w   = {DAC_CMD, CH1_ADDR, active_r1_reg};

    always_ff @(posedge user_clk_i or posedge user_rst_i) begin
        if (user_rst_i) begin
            state_reg     <= IDLE;
            upd_q_reg     <= 1'b0;
            pending_reg   <= 1'b0;
            ch_sel_reg    <= 1'b0;
            active_r0_reg <= 12'd0;
            active_r1_reg <= 12'd0;
            shift_reg     <= 15'd0;
            div_cnt_reg   <= 8'd0;
            bit_cnt_reg   <= 4'd0;
            sclk_reg      <= 1'b0;
            din_reg       <= 1'b0;
            cs_b_reg      <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            upd_q_reg <= servo_update_i;

            case (state_reg)
                IDLE: begin
                    if (upd_edge_w || pending_reg) begin
                        state_reg <= COMMIT;
                        busy_reg  <= 1'b1;
                    end
                end

                COMMIT: begin
                    active_r0_reg <= staging_w[0];
                    active_r1_reg <= staging_w[1];
                    pending_reg   <= 1'b0;
                    shift_reg     <= frame0_w[14:0];
                    din_reg       <= frame0_w[15];
                    cs_b_reg      <= 1'b0;
                    sclk_reg      <= 1'b0;
                    div_cnt_reg   <= 8'd0;
                    bit_cnt_reg   <= 4'd0;
                    ch_sel_reg    <= 1'b0;
                    state_reg     <= SHIFT;
                end

                SHIFT: begin
                    if (div_cnt_reg == DIV_LAST) begin
                        div_cnt_reg <= 8'd0;
                        if (!sclk_reg) begin
                            sclk_reg <= 1'b1;
                        end else begin
                            // Falling edge: the DAC has sampled this bit, present the next.
                            sclk_reg <= 1'b0;
                            if (bit_cnt_reg == 4'd15) begin
                                cs_b_reg  <= 1'b1;
                                din_reg   <= 1'b0;
                                state_reg <= GAP;
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                                din_reg     <= shift_reg[14];
                                shift_reg   <= {shift_reg[13:0], 1'b0};
                            end
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 8'd1;
                    end
                end

                GAP: begin
                    if (div_cnt_reg == DIV_LAST) begin
                        div_cnt_reg <= 8'd0;
                        if (!ch_sel_reg) begin
                            ch_sel_reg  <= 1'b1;
                            shift_reg   <= frame1_w[14:0];
                            din_reg     <= frame1_w[15];
                            cs_b_reg    <= 1'b0;
                            bit_cnt_reg <= 4'd0;
                            state_reg   <= SHIFT;
                        end else begin
                            busy_reg  <= 1'b0;
                            state_reg <= IDLE;
                        end
                    end else begin
                        div_cnt_reg <= div_cnt_reg + 8'd1;
                    end
                end

                default: state_reg <= IDLE;
            endcase

            // Requests arriving mid-transfer collapse into a single follow-up transfer.
            if (upd_edge_w && (state_reg != IDLE)) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign DAC_SCLK = sclk_reg;
    assign DAC_DIN  = din_reg;
    assign DAC_CS_B = cs_b_reg;
    assign busy_o   = busy_reg;
    assign vdd_r0_o = active_r0_reg;
    assign vdd_r1_o = active_r1_reg;

endmodule

// File: tb/tb_ritc_vdd_servo_dac_loader.sv
// Bench for the VDD servo DAC loader: decodes SPI frames from the pins and
// compares them with frames predicted from the staged/committed words.
`timescale 1ns/1ps
module tb_ritc_vdd_servo_dac_loader;

    localparam int CLK_DIV  = 4;
    localparam int XFER_LEN = 1 + 2 * (32 * CLK_DIV) + 2 * CLK_DIV;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        servo_addr = 1'b0;
    logic        servo_wr = 1'b0;
    logic        servo_update = 1'b0;
    logic [11:0] servo_word = 12'd0;
    logic        sclk;
    logic        din;
    logic        cs_b;
    logic        busy;
    logic [11:0] vdd_r0;
    logic [11:0] vdd_r1;

    int n_cmp = 0;
    int n_fail = 0;

    // Reference model: staged words as written by the bench.
    logic [11:0] model_stage [2];

    logic [15:0] frame_q [$];
    int          rise_q [$];
    int          bad_q [$];
    int          gap_q [$];
    int          busy_len_q [$];

    ritc_vdd_servo_dac_loader #(
        .CLK_DIV (CLK_DIV),
        .DAC_CMD (2'b11),
        .CH0_ADDR(2'b00),
        .CH1_ADDR(2'b01)
    ) dut (
        .user_clk_i    (clk),
        .user_rst_i    (rst),
        .servo_addr_i  (servo_addr),
        .servo_wr_i    (servo_wr),
        .servo_update_i(servo_update),
        .servo_i       (servo_word),
        .DAC_SCLK      (sclk),
        .DAC_DIN       (din),
        .DAC_CS_B      (cs_b),
        .busy_o        (busy),
        .vdd_r0_o      (vdd_r0),
        .vdd_r1_o      (vdd_r1)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] exp_frame(input int ch, input logic [11:0] w);
        return {2'b11, (ch == 0) ? 2'b00 : 2'b01, w};
    endfunction

    // Pin-level observer, sampled on the falling clock edge.
    initial begin
        logic        prev_sclk = 1'b0;
        logic        prev_cs = 1'b1;
        logic        prev_din = 1'b0;
        logic        prev_busy = 1'b0;
        logic [15:0] shreg = 16'd0;
        int          run_len = 0;
        int          rises = 0;
        int          bad = 0;
        int          cs_high_run = 0;
        int          busy_run = 0;
        forever begin
            @(negedge clk);
            if (prev_cs && !cs_b) begin
                gap_q.push_back(cs_high_run);
                rises = 0;
                bad = 0;
                shreg = 16'd0;
                run_len = 1;
            end else if (!cs_b) begin
                if (sclk == prev_sclk) begin
                    run_len++;
                end else begin
                    if (run_len != CLK_DIV) bad++;
                    run_len = 1;
                end
                if (sclk && !prev_sclk) begin
                    rises++;
                    shreg = {shreg[14:0], din};
                    if (din !== prev_din) bad++;
                end
            end else if (!prev_cs && cs_b) begin
                if (run_len != CLK_DIV) bad++;
                frame_q.push_back(shreg);
                rise_q.push_back(rises);
                bad_q.push_back(bad);
            end
            cs_high_run = cs_b ? (prev_cs ? cs_high_run + 1 : 1) : 0;
            if (busy) busy_run++;
            else if (prev_busy) begin
                busy_len_q.push_back(busy_run);
                busy_run = 0;
            end
            prev_sclk = sclk;
            prev_cs   = cs_b;
            prev_din  = din;
            prev_busy = busy;
        end
    end

    task automatic clear_obs();
        frame_q.delete();
        rise_q.delete();
        bad_q.delete();
        gap_q.delete();
        busy_len_q.delete();
    endtask

    task automatic do_write(input logic a, input logic [11:0] w);
        @(posedge clk); #1;
        servo_addr = a;
        servo_wr   = 1'b1;
        servo_word = w;
        @(posedge clk); #1;
        servo_wr = 1'b0;
        model_stage[a] = w;
    endtask

    task automatic pulse_update();
        @(posedge clk); #1;
        servo_update = 1'b1;
        @(posedge clk); #1;
        servo_update = 1'b0;
    endtask

    // Waits until busy has been low for 3 consecutive samples.
    task automatic wait_idle(input int max_cycles, output bit ok);
        int low = 0;
        ok = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            @(negedge clk);
            low = busy ? 0 : low + 1;
            if (low >= 3) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if ({cs_b, sclk, din, busy, vdd_r0, vdd_r1} !== {4'b1000, 24'd0}) begin
            n_fail++;
            $display("FAIL reset_outputs: got cs_b=%b sclk=%b din=%b busy=%b r0=%h r1=%h, want 1 0 0 0 000 000",
                     cs_b, sclk, din, busy, vdd_r0, vdd_r1);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++;
        if (frame_q.size() != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got frames=%0d busy=%b, want 0 0", frame_q.size(), busy);
        end
        $display("reset: released, idle checked");
    endtask

    task automatic test_transfer(input logic [11:0] w0, input logic [11:0] w1);
        bit ok;
        clear_obs();
        do_write(1'b0, w0);
        do_write(1'b1, w1);
        pulse_update();
        wait_idle(2000, ok);
        n_cmp++;
        if (!ok) begin
            n_fail++;
            $display("FAIL xfer_timeout: busy still high after 2000 cycles, want idle");
            return;
        end
        n_cmp++;
        if (frame_q.size() != 2) begin
            n_fail++;
            $display("FAIL xfer_count: got %0d frames, want 2", frame_q.size());
            return;
        end
        n_cmp++;
        if (frame_q[0] !== exp_frame(0, w0) || frame_q[1] !== exp_frame(1, w1)) begin
            n_fail++;
            $display("FAIL xfer_frames: got %h %h, want %h %h",
                     frame_q[0], frame_q[1], exp_frame(0, w0), exp_frame(1, w1));
        end
        n_cmp++;
        if (vdd_r0 !== w0 || vdd_r1 !== w1) begin
            n_fail++;
            $display("FAIL xfer_active: got r0=%h r1=%h, want %h %h", vdd_r0, vdd_r1, w0, w1);
        end
        n_cmp++;
        if (busy_len_q.size() != 1 || busy_len_q[0] != XFER_LEN) begin
            n_fail++;
            $display("FAIL xfer_busy_len: got %0d runs first=%0d, want 1 run of %0d",
                     busy_len_q.size(), (busy_len_q.size() > 0) ? busy_len_q[0] : -1, XFER_LEN);
        end
        n_cmp++;
        if (rise_q[0] != 16 || rise_q[1] != 16 || bad_q[0] != 0 || bad_q[1] != 0) begin
            n_fail++;
            $display("FAIL xfer_sclk_timing: got rises %0d/%0d timing_errs %0d/%0d, want 16/16 0/0",
                     rise_q[0], rise_q[1], bad_q[0], bad_q[1]);
        end
        n_cmp++;
        if (gap_q.size() != 2 || gap_q[1] != CLK_DIV) begin
            n_fail++;
            $display("FAIL xfer_gap: got cs_b high %0d cycles between frames, want %0d",
                     (gap_q.size() > 1) ? gap_q[1] : -1, CLK_DIV);
        end
        $display("transfer: r0=%h r1=%h frames=%h %h", w0, w1, frame_q[0], frame_q[1]);
    endtask

    task automatic test_pending();
        bit ok;
        logic [11:0] a0, a1, n0;
        logic [15:0] want [4];
        a0 = 12'($urandom);
        a1 = 12'($urandom);
        n0 = 12'($urandom);
        clear_obs();
        do_write(1'b0, a0);
        do_write(1'b1, a1);
        pulse_update();
        repeat (20) @(posedge clk);
        do_write(1'b0, n0);
        for (int k = 0; k < 3; k++) begin
            pulse_update();
            repeat (3) @(posedge clk);
        end
        @(negedge clk);
        n_cmp++;
        if (vdd_r0 !== a0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_midframe: got r0=%h busy=%b, want %h 1", vdd_r0, busy, a0);
        end
        wait_idle(3000, ok);
        want[0] = exp_frame(0, a0);
        want[1] = exp_frame(1, a1);
        want[2] = exp_frame(0, n0);
        want[3] = exp_frame(1, a1);
        n_cmp++;
        if (!ok || frame_q.size() != 4) begin
            n_fail++;
            $display("FAIL pending_count: got idle=%0b frames=%0d, want 1 4", ok, frame_q.size());
            return;
        end
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if (frame_q[k] !== want[k]) begin
                n_fail++;
                $display("FAIL pending_frame%0d: got %h, want %h", k, frame_q[k], want[k]);
            end
        end
        n_cmp++;
        if (vdd_r0 !== n0 || vdd_r1 !== a1) begin
            n_fail++;
            $display("FAIL pending_active: got r0=%h r1=%h, want %h %h", vdd_r0, vdd_r1, n0, a1);
        end
        $display("pending: frames=%h %h %h %h", frame_q[0], frame_q[1], frame_q[2], frame_q[3]);
    endtask

    task automatic test_held_update();
        bit ok;
        logic [11:0] w0, w1;
        w0 = 12'($urandom);
        w1 = 12'($urandom);
        do_write(1'b0, w0);
        do_write(1'b1, w1);
        clear_obs();
        @(posedge clk); #1;
        servo_update = 1'b1;
        repeat (1000) @(posedge clk);
        #1;
        servo_update = 1'b0;
        wait_idle(2000, ok);
        n_cmp++;
        if (!ok || frame_q.size() != 2 || busy_len_q.size() != 1) begin
            n_fail++;
            $display("FAIL held_count: got idle=%0b frames=%0d transfers=%0d, want 1 2 1",
                     ok, frame_q.size(), busy_len_q.size());
            return;
        end
        n_cmp++;
        if (frame_q[0] !== exp_frame(0, w0) || frame_q[1] !== exp_frame(1, w1)) begin
            n_fail++;
            $display("FAIL held_frames: got %h %h, want %h %h",
                     frame_q[0], frame_q[1], exp_frame(0, w0), exp_frame(1, w1));
        end
        $display("held update: single transfer frames=%h %h", frame_q[0], frame_q[1]);
    endtask

    task automatic test_reset_midframe();
        bit started;
        do_write(1'b0, 12'($urandom));
        do_write(1'b1, 12'($urandom));
        pulse_update();
        started = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (frame_q.size() == 0) clear_obs();
            if (!cs_b && gap_q.size() >= 1 && gap_q[gap_q.size() - 1] == CLK_DIV) begin
                started = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (!started) begin
            n_fail++;
            $display("FAIL rstmid_frame1_start: frame1 never began, want start within 400 cycles");
        end
        repeat (40) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({cs_b, sclk, busy, vdd_r0, vdd_r1} !== {3'b100, 24'd0}) begin
            n_fail++;
            $display("FAIL rstmid_async: got cs_b=%b sclk=%b busy=%b r0=%h r1=%h, want 1 0 0 000 000",
                     cs_b, sclk, busy, vdd_r0, vdd_r1);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_stage[0] = 12'd0;
        model_stage[1] = 12'd0;
        clear_obs();
        repeat (400) @(negedge clk);
        n_cmp++;
        if (frame_q.size() != 0 || busy !== 1'b0 || cs_b !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_quiet: got frames=%0d busy=%b cs_b=%b, want 0 0 1",
                     frame_q.size(), busy, cs_b);
        end
        $display("reset mid-frame: outputs cleared, no frames after release");
    endtask

    task automatic test_same_cycle();
        bit ok;
        clear_obs();
        @(posedge clk); #1;
        servo_addr   = 1'b1;
        servo_wr     = 1'b1;
        servo_word   = 12'hABC;
        servo_update = 1'b1;
        @(posedge clk); #1;
        servo_wr     = 1'b0;
        servo_update = 1'b0;
        model_stage[1] = 12'hABC;
        wait_idle(2000, ok);
        n_cmp++;
        if (!ok || frame_q.size() != 2) begin
            n_fail++;
            $display("FAIL same_cycle_count: got idle=%0b frames=%0d, want 1 2", ok, frame_q.size());
            return;
        end
        n_cmp++;
        if (frame_q[0] !== exp_frame(0, model_stage[0]) || frame_q[1] !== 16'hDABC || vdd_r1 !== 12'hABC) begin
            n_fail++;
            $display("FAIL same_cycle_frames: got %h %h r1=%h, want %h dabc abc",
                     frame_q[0], frame_q[1], vdd_r1, exp_frame(0, model_stage[0]));
        end
        $display("same-cycle write+update: frame1=%h", frame_q[1]);
    endtask

    initial begin
        model_stage[0] = 12'd0;
        model_stage[1] = 12'd0;
        test_reset();
        test_transfer(12'h5A3, 12'h0F1);
        for (int k = 0; k < 3; k++) test_transfer(12'($urandom), 12'($urandom));
        test_pending();
        test_held_update();
        test_reset_midframe();
        test_same_cycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
